// File: rtl/dvi_video_pipeline_pkg.sv
// Shared defaults, test-pattern encodings, bar colour table and the
// record carried down the pixel delay line.
package dvi_video_pipeline_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_PIX_LATENCY = 2;
   localparam int DEF_COLOR_WIDTH = 8;
   localparam logic [23:0] DEF_SOLID_RGB = 24'hFF0000;

   typedef enum logic [1:0] {
      PAT_PASS  = 2'd0,
      PAT_BARS  = 2'd1,
      PAT_SOLID = 2'd2,
      PAT_CHECK = 2'd3
   } pat_mode_t;

   // One request-stage snapshot; sync bits are "active" flags, not pin levels.
   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic        ls;
      logic        fs;
      logic        use_pat;
      logic [23:0] pix;
   } pipe_t;

   function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
      logic [23:0] c;
      c = 24'h000000;
      case (idx)
         3'd0: c = 24'hFFFFFF;
         3'd1: c = 24'hFFFF00;
         3'd2: c = 24'h00FFFF;
         3'd3: c = 24'h00FF00;
         3'd4: c = 24'hFF00FF;
         3'd5: c = 24'hFF0000;
         3'd6: c = 24'h0000FF;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/dvi_video_pipeline_timing_counter.sv
// Raster position counters plus active-region, sync and start-of-line/frame
// decode, all at the request stage.
module dvi_video_pipeline_timing_counter #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int XW      = $clog2(H_TOTAL),
   localparam int YW      = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic [XW-1:0] h,
   output logic [YW-1:0] v,
   output logic          h_last,
   output logic          active,
   output logic          hs_act,
   output logic          vs_act,
   output logic          line_first,
   output logic          frame_first
);

   assign h_last = (h == XW'(H_TOTAL - 1));

   // h wraps every line; v advances on the same edge h wraps, so both reach 0 together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h <= '0;
         v <= '0;
      end else if (en) begin
         if (h_last) begin
            h <= '0;
            v <= (v == YW'(V_TOTAL - 1)) ? '0 : v + YW'(1);
         end else begin
            h <= h + XW'(1);
         end
      end
   end

   assign active      = (h < XW'(H_ACTIVE)) && (v < YW'(V_ACTIVE));
   assign hs_act      = (h >= XW'(H_ACTIVE + H_FP)) && (h < XW'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_act      = (v >= YW'(V_ACTIVE + V_FP)) && (v < YW'(V_ACTIVE + V_FP + V_SYNC));
   assign line_first  = active && (h == '0);
   assign frame_first = line_first && (v == '0);

endmodule

// File: rtl/dvi_video_pipeline.sv
// DVI output pipeline: programmable raster timing, pixel requests to the frame
// source, latency-matched control delay, optional test patterns and 12-bit
// half-word packing for an external DDR output cell.
module dvi_video_pipeline
   import dvi_video_pipeline_pkg::*;
#(
   parameter int          H_ACTIVE    = DEF_H_ACTIVE,
   parameter int          H_FP        = DEF_H_FP,
   parameter int          H_SYNC      = DEF_H_SYNC,
   parameter int          H_BP        = DEF_H_BP,
   parameter int          V_ACTIVE    = DEF_V_ACTIVE,
   parameter int          V_FP        = DEF_V_FP,
   parameter int          V_SYNC      = DEF_V_SYNC,
   parameter int          V_BP        = DEF_V_BP,
   parameter bit          SYNC_POL    = 1'b0,
   parameter int          PIX_LATENCY = DEF_PIX_LATENCY,
   parameter int          COLOR_WIDTH = DEF_COLOR_WIDTH,
   parameter logic [23:0] SOLID_RGB   = DEF_SOLID_RGB,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int XW      = $clog2(H_TOTAL),
   localparam int YW      = $clog2(V_TOTAL)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [1:0]             pattern_sel,
   input  logic [COLOR_WIDTH-1:0] r,
   input  logic [COLOR_WIDTH-1:0] g,
   input  logic [COLOR_WIDTH-1:0] b,
   output logic                   pix_req,
   output logic [XW-1:0]          x,
   output logic [YW-1:0]          y,
   output logic                   chip_data_enable,
   output logic                   chip_hsync,
   output logic                   chip_vsync,
   output logic                   chip_reset,
   output logic [11:0]            chip_data_lo,
   output logic [11:0]            chip_data_hi,
   output logic                   xclk,
   output logic                   xclk_n,
   output logic                   frame_start,
   output logic                   line_start
);

   localparam int BAR_W = H_ACTIVE / 8;
   localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   logic [XW-1:0] h;
   logic [YW-1:0] v;
   logic          h_last, active, hs_act, vs_act, line_first, frame_first;

   dvi_video_pipeline_timing_counter #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk(clk), .rst(reset), .en(enable),
      .h(h), .v(v), .h_last(h_last), .active(active),
      .hs_act(hs_act), .vs_act(vs_act),
      .line_first(line_first), .frame_first(frame_first)
   );

   // The request is live from the counter so pixel (0,0) is asked for in the
   // very first cycle after reset; masking with reset keeps it low meanwhile.
   assign pix_req = active & ~reset;

   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;

   // Remember the last requested position so x/y hold through blanking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
      end else if (enable && active) begin
         x_q <= h;
         y_q <= v;
      end
   end

   assign x = active ? h : x_q;
   assign y = active ? v : y_q;

   // pattern_sel is taken live at (0,0) so the new mode covers that pixel too.
   pat_mode_t mode_q, mode_cur;
   assign mode_cur = (h == '0 && v == '0) ? pat_mode_t'(pattern_sel) : mode_q;

   // Latch the frame's pattern mode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) mode_q <= PAT_PASS;
      else if (enable) mode_q <= mode_cur;
   end

   logic [BW-1:0] bar_cnt;
   logic [2:0]    bar_idx;

   // Track which colour bar the request column is in, restarting every line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bar_cnt <= '0;
         bar_idx <= '0;
      end else if (enable) begin
         if (h_last) begin
            bar_cnt <= '0;
            bar_idx <= '0;
         end else if (h < XW'(H_ACTIVE)) begin
            if (bar_cnt == BW'(BAR_W - 1)) begin
               bar_cnt <= '0;
               bar_idx <= bar_idx + 3'd1;
            end else begin
               bar_cnt <= bar_cnt + BW'(1);
            end
         end
      end
   end

   // Checker squares are 16 pixels; masking bit 4 keeps this legal for narrow counters.
   logic chk_bit;
   assign chk_bit = (|(h & XW'(16))) ^ (|(v & YW'(16)));

   logic [23:0] pat_pix;

   // Pattern pixel at the request stage, travelling with its controls.
   always_comb begin
      pat_pix = 24'h000000;
      case (mode_cur)
         PAT_BARS:  pat_pix = bar_rgb(bar_idx);
         PAT_SOLID: pat_pix = SOLID_RGB;
         PAT_CHECK: pat_pix = chk_bit ? 24'hFFFFFF : 24'h000000;
         default:   pat_pix = 24'h000000;
      endcase
   end

   pipe_t req_stage, tail;
   assign req_stage = '{hs: hs_act, vs: vs_act, de: active, ls: line_first,
                        fs: frame_first, use_pat: (mode_cur != PAT_PASS), pix: pat_pix};

   if (PIX_LATENCY == 0) begin : g_no_dly
      assign tail = req_stage;
   end else begin : g_dly
      pipe_t stage [PIX_LATENCY];

      // Delay the request-stage record by the source read latency.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < PIX_LATENCY; i++) stage[i] <= '0;
         end else if (enable) begin
            stage[0] <= req_stage;
            for (int i = 1; i < PIX_LATENCY; i++) stage[i] <= stage[i-1];
         end
      end

      assign tail = stage[PIX_LATENCY-1];
   end

   logic [7:0]  r8, g8, b8;
   logic [23:0] sel_pix;
   assign r8 = 8'(r) << (8 - COLOR_WIDTH);
   assign g8 = 8'(g) << (8 - COLOR_WIDTH);
   assign b8 = 8'(b) << (8 - COLOR_WIDTH);
   assign sel_pix = tail.use_pat ? tail.pix : {r8, g8, b8};

   // Output register: pin levels, blanked data and start pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chip_data_enable <= 1'b0;
         chip_hsync       <= ~SYNC_POL;
         chip_vsync       <= ~SYNC_POL;
         chip_data_lo     <= '0;
         chip_data_hi     <= '0;
         frame_start      <= 1'b0;
         line_start       <= 1'b0;
      end else if (enable) begin
         chip_data_enable <= tail.de;
         chip_hsync       <= tail.hs ? SYNC_POL : ~SYNC_POL;
         chip_vsync       <= tail.vs ? SYNC_POL : ~SYNC_POL;
         chip_data_lo     <= tail.de ? {sel_pix[11:8], sel_pix[7:0]} : 12'h000;
         chip_data_hi     <= tail.de ? {sel_pix[23:16], sel_pix[15:12]} : 12'h000;
         frame_start      <= tail.fs;
         line_start       <= tail.ls;
      end
   end

   assign chip_reset = 1'b1;
   assign xclk       = ~clk;
   assign xclk_n     = clk;

endmodule
